// File: rtl/reg_file.sv
// Register file with Y86-style write-back decode.
// Two write ports (E and M) are driven from the retiring instruction.
// Reads are combinational from stored state, with no bypass of same-cycle writes.
// The block also keeps a sticky halt flag and a saturating count of retired writes.
module reg_file #(
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200,
  parameter int unsigned NREG     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [63:0] reg_memrA,
  output logic [63:0] reg_memrB,
  output logic [63:0] reg_memr4,
  output logic        halted,
  output logic [15:0] wr_count
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  logic [63:0] regs_r [NREG];
  logic        halted_r;
  logic [15:0] wr_count_r;

  logic [3:0]  dst_e_s;
  logic [3:0]  dst_m_s;
  logic        is_halt_s;
  logic        we_e_s;
  logic        we_m_s;
  logic [1:0]  inc_s;
  logic [16:0] sum_s;
  logic [15:0] next_count_s;

  // A write target is real only when it names an implemented register.
  function automatic logic dst_valid(input logic [3:0] dst);
    return (dst != REG_NONE) && ({28'd0, dst} < NREG);
  endfunction

  // Decode write-back destinations from the retiring instruction code.
  always_comb begin
    dst_e_s   = REG_NONE;
    dst_m_s   = REG_NONE;
    is_halt_s = 1'b0;
    case (icode)
      4'h0: is_halt_s = 1'b1;
      4'h2: begin
        if (cnd) begin
          dst_e_s = rB;
        end else begin
          dst_e_s = REG_NONE;
        end
      end
      4'h3: dst_e_s = rB;
      4'h5: dst_m_s = rA;
      4'h6: dst_e_s = rB;
      4'h8: dst_e_s = REG_RSP;
      4'h9: dst_e_s = REG_RSP;
      4'hA: dst_e_s = REG_RSP;
      4'hB: begin
        dst_e_s = REG_RSP;
        dst_m_s = rA;
      end
      default: begin
        dst_e_s   = REG_NONE;
        dst_m_s   = REG_NONE;
        is_halt_s = 1'b0;
      end
    endcase
  end

  // Qualify port enables. Port M takes priority when both ports target one register.
  always_comb begin
    we_m_s = 1'b0;
    we_e_s = 1'b0;
    if (wb_en && !halted_r) begin
      we_m_s = dst_valid(dst_m_s);
      we_e_s = dst_valid(dst_e_s) && !(we_m_s && (dst_e_s == dst_m_s));
    end else begin
      we_m_s = 1'b0;
      we_e_s = 1'b0;
    end
  end

  // Compute the next write count, saturating at all-ones.
  always_comb begin
    inc_s = {1'b0, we_e_s} + {1'b0, we_m_s};
    sum_s = {1'b0, wr_count_r} + {15'd0, inc_s};
    if (sum_s[16]) begin
      next_count_s = 16'hFFFF;
    end else begin
      next_count_s = sum_s[15:0];
    end
  end

  // Register array, halt flag and write counter, with a synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_r[i] <= (i == 32'sd4) ? RSP_INIT : 64'd0;
      end
      halted_r   <= 1'b0;
      wr_count_r <= 16'd0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (we_e_s && (dst_e_s == i[3:0])) begin
          regs_r[i] <= valE;
        end
        if (we_m_s && (dst_m_s == i[3:0])) begin
          regs_r[i] <= valM;
        end
      end
      if (wb_en && !halted_r && is_halt_s) begin
        halted_r <= 1'b1;
      end
      wr_count_r <= next_count_s;
    end
  end

  // Combinational read ports. A select of "no register" or out of range reads zero.
  always_comb begin
    if (dst_valid(rA)) begin
      reg_memrA = regs_r[rA];
    end else begin
      reg_memrA = 64'd0;
    end
    if (dst_valid(rB)) begin
      reg_memrB = regs_r[rB];
    end else begin
      reg_memrB = 64'd0;
    end
  end

  assign reg_memr4 = regs_r[REG_RSP];
  assign halted    = halted_r;
  assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write-back decode, popq port priority,
// halt blocking, reset overriding a write, and counter saturation.
module tb_reg_file;

  localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [63:0] reg_memrA;
  logic [63:0] reg_memrB;
  logic [63:0] reg_memr4;
  logic        halted;
  logic [15:0] wr_count;

  int vectors;
  int miscompares;

  reg_file #(.RSP_INIT(RSP_INIT), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .reg_memrA(reg_memrA),
    .reg_memrB(reg_memrB), .reg_memr4(reg_memr4), .halted(halted),
    .wr_count(wr_count)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Retire one instruction through a single clock edge, then drop the strobe.
  task automatic wb(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                    input logic c, input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = 1'b1;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  // Select read ports and let the combinational outputs settle.
  task automatic sel(input logic [3:0] a, input logic [3:0] b);
    rA = a; rB = b; #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; wb_en = 1'b0; icode = 4'h1; rA = 4'h0; rB = 4'h7;
    cnd = 1'b0; valE = 64'd0; valM = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_r4", reg_memr4, RSP_INIT);
    check("rst_rA0", reg_memrA, 64'd0);
    check("rst_rB7", reg_memrB, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_count", {48'd0, wr_count}, 64'd0);
    rst_n = 1'b1;

    wb(4'h3, 4'h0, 4'h2, 1'b0, 64'h1234, 64'd0);
    sel(4'h0, 4'h2);
    check("irmovq_rB2", reg_memrB, 64'h1234);
    check("irmovq_count", {48'd0, wr_count}, 64'd1);

    wb(4'h2, 4'h0, 4'h3, 1'b0, 64'hAA, 64'd0);
    sel(4'h0, 4'h3);
    check("cmov_nc_r3", reg_memrB, 64'd0);
    check("cmov_nc_count", {48'd0, wr_count}, 64'd1);
    wb(4'h2, 4'h0, 4'h3, 1'b1, 64'hAA, 64'd0);
    sel(4'h0, 4'h3);
    check("cmov_c_r3", reg_memrB, 64'hAA);
    check("cmov_c_count", {48'd0, wr_count}, 64'd2);

    icode = 4'h3; rB = 4'h6; valE = 64'h99; wb_en = 1'b0;
    @(posedge clk); #1;
    sel(4'h0, 4'h6);
    check("wben0_r6", reg_memrB, 64'd0);
    check("wben0_count", {48'd0, wr_count}, 64'd2);

    wb(4'hC, 4'h6, 4'h6, 1'b1, 64'h77, 64'h88);
    sel(4'h6, 4'h6);
    check("inv_r6", reg_memrB, 64'd0);
    check("inv_count", {48'd0, wr_count}, 64'd2);
    check("inv_halted", {63'd0, halted}, 64'd0);

    wb(4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hDEAD);
    check("popq_rsp_r4", reg_memr4, 64'hDEAD);
    check("popq_rsp_count", {48'd0, wr_count}, 64'd3);
    wb(4'hB, 4'h1, 4'hF, 1'b0, 64'h208, 64'hDEAD);
    sel(4'h1, 4'hF);
    check("popq_r1_r4", reg_memr4, 64'h208);
    check("popq_r1_r1", reg_memrA, 64'hDEAD);
    check("popq_r1_count", {48'd0, wr_count}, 64'd5);

    wb(4'h5, 4'h7, 4'hF, 1'b0, 64'h11, 64'h77);
    sel(4'h7, 4'h0);
    check("mrmovq_r7", reg_memrA, 64'h77);
    check("mrmovq_count", {48'd0, wr_count}, 64'd6);

    wb(4'hA, 4'h0, 4'h0, 1'b0, 64'h1F0, 64'h5);
    check("pushq_r4", reg_memr4, 64'h1F0);
    check("pushq_count", {48'd0, wr_count}, 64'd7);

    wb(4'h3, 4'hF, 4'hF, 1'b0, 64'h55, 64'd0);
    sel(4'hF, 4'hF);
    check("selF_rA", reg_memrA, 64'd0);
    check("selF_rB", reg_memrB, 64'd0);
    check("selF_count", {48'd0, wr_count}, 64'd7);
    check("selF_r4", reg_memr4, 64'h1F0);
    sel(4'h2, 4'h3);
    check("selF_r2", reg_memrA, 64'h1234);
    check("selF_r3", reg_memrB, 64'hAA);

    wb(4'h0, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0);
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_count", {48'd0, wr_count}, 64'd7);
    wb(4'h6, 4'h0, 4'h5, 1'b0, 64'h7, 64'd0);
    sel(4'h2, 4'h5);
    check("halted_r5", reg_memrB, 64'd0);
    check("halted_count", {48'd0, wr_count}, 64'd7);
    check("halted_sticky", {63'd0, halted}, 64'd1);
    check("halted_live_r2", reg_memrA, 64'h1234);

    rst_n = 1'b0;
    wb(4'hA, 4'h0, 4'h0, 1'b0, 64'h1F8, 64'd0);
    rst_n = 1'b1;
    sel(4'h2, 4'h3);
    check("rstw_r4", reg_memr4, RSP_INIT);
    check("rstw_r2", reg_memrA, 64'd0);
    check("rstw_r3", reg_memrB, 64'd0);
    sel(4'h1, 4'h7);
    check("rstw_r1", reg_memrA, 64'd0);
    check("rstw_r7", reg_memrB, 64'd0);
    check("rstw_halted", {63'd0, halted}, 64'd0);
    check("rstw_count", {48'd0, wr_count}, 64'd0);

    wb(4'h3, 4'h0, 4'h2, 1'b0, 64'h1, 64'd0);
    sel(4'h0, 4'h2);
    check("first_wr_r2", reg_memrB, 64'h1);
    check("first_wr_count", {48'd0, wr_count}, 64'd1);

    // Drive the counter to its ceiling: 32767 double-port pops bring it to 16'hFFFF.
    icode = 4'hB; rA = 4'h1; valE = 64'h208; valM = 64'h3; wb_en = 1'b1;
    repeat (32767) @(posedge clk);
    #1;
    check("sat_reach", {48'd0, wr_count}, 64'hFFFF);
    @(posedge clk); #1;
    wb_en = 1'b0;
    check("sat_hold", {48'd0, wr_count}, 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
